// File: rtl/shared_bus_rr_arbiter.sv
// Round-robin arbiter/sequencer for a 4-source tristate bus with a dead turnaround cycle between owners.
// Define ARB_HOLD_LIMIT_EN to cap each tenure at HOLD_MAX cycles when other sources are waiting.
module shared_bus_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [4*DATA_W-1:0] din,
    output logic [3:0]          gnt,
    output logic [1:0]          sel,
    output logic                bus_en,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        ptr;
    logic [1:0]        winner;
    logic [DATA_W-1:0] lane;
    logic              keep;

    if (HOLD_MAX < 1) begin : g_bad_hold_max
        $error("HOLD_MAX must be at least 1");
    end

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        winner = ptr + 2'd1;
        for (int i = 4; i >= 1; i--) begin
            if (req[ptr + 2'(i)]) winner = ptr + 2'(i);
        end
    end

    always_comb begin
        lane = '0;
        for (int k = 0; k < 4; k++) begin
            if (sel == 2'(k)) lane = din[k*DATA_W +: DATA_W];
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HCNT_W = $clog2(HOLD_MAX + 1);

    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] hcnt_inc;
    logic              hold_hit;

    // hcnt_inc reaching HOLD_MAX means the cycle closing now is the owner's last allowed one.
    assign hcnt_inc = (hcnt == HCNT_W'(HOLD_MAX)) ? hcnt : hcnt + HCNT_W'(1);
    assign hold_hit = (hcnt_inc == HCNT_W'(HOLD_MAX)) && |(req & ~gnt);
    assign keep     = req[sel] && !hold_hit;

    always_ff @(posedge clk) begin
        if (rst || state != GRANT) hcnt <= '0;
        else                       hcnt <= hcnt_inc;
    end
`else
    assign keep = req[sel];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 2'd3;
            gnt        <= '0;
            sel        <= '0;
            bus_en     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, TURNAROUND: begin
                    dout_valid <= 1'b0;
                    if (|req) begin
                        state  <= GRANT;
                        gnt    <= 4'b0001 << winner;
                        sel    <= winner;
                        bus_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (keep) begin
                        dout       <= lane;
                        dout_valid <= 1'b1;
                    end else begin
                        state      <= TURNAROUND;
                        gnt        <= '0;
                        bus_en     <= 1'b0;
                        ptr        <= sel;
                        dout_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    gnt        <= '0;
                    bus_en     <= 1'b0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bus_rr_arbiter.sv
// Self-checking bench for shared_bus_rr_arbiter: directed scenarios plus random traffic
// compared each cycle against an ownership-level reference model.
module tb_shared_bus_rr_arbiter;

    localparam int DATA_W   = 8;
    localparam int HOLD_MAX = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [3:0]          req = '0;
    logic [4*DATA_W-1:0] din = '0;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic                bus_en;
    logic [DATA_W-1:0]   dout;
    logic                dout_valid;

    always #5 clk = ~clk;

    shared_bus_rr_arbiter #(
        .DATA_W  (DATA_W),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .sel       (sel),
        .bus_en    (bus_en),
        .dout      (dout),
        .dout_valid(dout_valid)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who owns the bus, who owned it last, and how long the owner has held it.
    int          owner   = -1;
    int          last    = 3;
    int          held    = 0;
    logic [1:0]  m_sel   = '0;
    logic [7:0]  m_dout  = '0;
    logic        m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] rq, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (rq[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit r, input logic [3:0] rq, input logic [31:0] d);
        bit force_rel;
        force_rel = 1'b0;
        if (r) begin
            owner   = -1;
            last    = 3;
            held    = 0;
            m_sel   = '0;
            m_dout  = '0;
            m_valid = 1'b0;
        end else if (owner >= 0) begin
`ifdef ARB_HOLD_LIMIT_EN
            force_rel = (held + 1 >= HOLD_MAX) && ((rq & ~(4'b0001 << owner)) != 4'b0000);
`endif
            if (!rq[owner] || force_rel) begin
                last    = owner;
                owner   = -1;
                m_valid = 1'b0;
            end else begin
                m_dout  = 8'(d >> (8 * owner));
                m_valid = 1'b1;
                held    = (held + 1 > HOLD_MAX) ? HOLD_MAX : held + 1;
            end
        end else if (rq != 4'b0000) begin
            owner = pick(rq, last);
            m_sel = 2'(owner);
            held  = 0;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] exp_gnt;
        exp_gnt = (owner >= 0) ? 4'(4'b0001 << owner) : 4'b0000;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("sel", 32'(sel), 32'(m_sel));
        check("bus_en", 32'(bus_en), 32'(owner >= 0));
        check("dout", 32'(dout), 32'(m_dout));
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic step(input bit r, input logic [3:0] rq, input logic [31:0] d);
        @(negedge clk);
        rst = r;
        req = rq;
        din = d;
        @(posedge clk);
        model_edge(r, rq, d);
        #1;
        check_outputs();
    endtask

    // Every requester stays up, except the owner drops once it has been granted for two cycles.
    task automatic contend(input logic [3:0] base, input int cycles);
        logic [3:0] rq;
        for (int c = 0; c < cycles; c++) begin
            rq = base;
            if (owner >= 0 && held >= 1) rq[owner] = 1'b0;
            step(1'b0, rq, $urandom);
        end
    endtask

    initial begin
        // Reset held with every source requesting; then first grant goes to source 0.
        step(1'b1, 4'b1111, 32'h0);
        step(1'b1, 4'b1111, 32'h0);
        step(1'b0, 4'b1111, 32'h0);
        check("first_grant", 32'(gnt), 32'h1);

        // Single source with a fixed lane value, then release into idle.
        step(1'b1, 4'b0000, 32'h0);
        for (int c = 0; c < 5; c++) step(1'b0, 4'b0100, 32'h00A5_0000);
        check("single_dout", 32'(dout), 32'hA5);
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0000, 32'h00A5_0000);

        // Full contention: order 0,1,2,3 with one dead cycle between owners.
        step(1'b1, 4'b0000, 32'h0);
        contend(4'b1111, 24);

        // Rotation: source 1 releases while 0 and 3 wait, so 3 wins next.
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b0010, 32'h0);
        step(1'b0, 4'b0010, 32'h0);
        step(1'b0, 4'b1001, 32'h0);
        step(1'b0, 4'b1001, 32'h0);
        check("rotation_gnt", 32'(gnt), 32'h8);
        contend(4'b1001, 12);

        // Two sources requesting constantly: the hold limit decides whether they alternate.
        step(1'b1, 4'b0000, 32'h0);
        for (int c = 0; c < 20; c++) step(1'b0, 4'b0011, $urandom);

        // Reset in the third cycle of a grant to source 2.
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b0100, 32'h0077_0000);
        step(1'b0, 4'b0100, 32'h0077_0000);
        step(1'b1, 4'b0100, 32'h0077_0000);
        check("midrst_dout", 32'(dout), 32'h0);
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0101, 32'h0);

        // Random traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(63) == 0), 4'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
